// File: rtl/neuron_body_gen2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// neuron_body_gen2
//
// SRM0 neuron soma for a gamma-clocked temporal pipeline. Each cycle the
// number of high synapse response bits is added to a saturating membrane
// potential. A linear leak can optionally be applied. When the potential
// reaches the threshold latched at the start of the gamma cycle, the neuron
// fires once for that gamma cycle and reports the time of firing. The firing
// event is stretched into a 2^WRES-cycle pulse for the next layer.
//
// Ports
//   clk          unit clock
//   rstb         synchronous active-low reset; dominates grst
//   grst         1-cycle gamma-cycle start pulse
//   acc_in       unary synapse responses, one potential unit per high bit
//   thresh       firing threshold, captured on grst
//   output_spike 2^WRES-cycle output pulse, starts the cycle after a fire
//   spike_time   time counter value at the last fire; held until the next one
//   spike_valid  1-cycle strobe, spike_time has just been updated
//   no_spike     1-cycle strobe at grst if the previous gamma cycle was silent
//   potential    current membrane potential
// -----------------------------------------------------------------------------
module neuron_body_gen2 #(
    parameter int INP         = 16,
    parameter int WRES        = 3,
    parameter int POT_W       = 8,
    parameter int TW          = 4,
    parameter int LEAK_EN     = 0,
    parameter int LEAK_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             grst,
    input  logic [INP-1:0]   acc_in,
    input  logic [POT_W-1:0] thresh,
    output logic             output_spike,
    output logic [TW-1:0]    spike_time,
    output logic             spike_valid,
    output logic             no_spike,
    output logic [POT_W-1:0] potential
);

    localparam int SUM_W = $clog2(INP + 1);
    localparam int LC_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int PC_W  = WRES + 1;

    localparam logic [POT_W:0]   POT_MAX   = {1'b0, {POT_W{1'b1}}};
    localparam logic [TW-1:0]    TCNT_MAX  = {TW{1'b1}};
    localparam logic [PC_W-1:0]  PULSE_LEN = PC_W'(2 ** WRES);
    localparam logic [LC_W-1:0]  LEAK_LAST = LC_W'(LEAK_PERIOD - 1);

    // State registers
    logic [POT_W-1:0] pot_q,         pot_d;
    logic [POT_W-1:0] thresh_q,      thresh_d;
    logic [TW-1:0]    tcnt_q,        tcnt_d;
    logic [LC_W-1:0]  leak_cnt_q,    leak_cnt_d;
    logic             fired_q,       fired_d;
    logic [PC_W-1:0]  pulse_cnt_q,   pulse_cnt_d;
    logic [TW-1:0]    spike_time_q,  spike_time_d;
    logic             spike_valid_q, spike_valid_d;
    logic             no_spike_q,    no_spike_d;

    // Datapath intermediates
    logic [SUM_W-1:0] sum;
    logic [POT_W:0]   pot_sum;
    logic [POT_W-1:0] pot_sat;
    logic [POT_W-1:0] pot_next;
    logic             leak;
    logic             fire;

    // Population count of the unary synapse responses
    always_comb begin
        sum = '0;
        for (int i = 0; i < INP; i++) begin
            sum = sum + SUM_W'(acc_in[i]);
        end
    end

    // Accumulate one bit wider than the potential so saturation is exact,
    // then apply the leak with a floor at zero.
    always_comb begin
        pot_sum  = {1'b0, pot_q} + (POT_W + 1)'(sum);
        pot_sat  = (pot_sum > POT_MAX) ? POT_MAX[POT_W-1:0] : pot_sum[POT_W-1:0];
        leak     = (LEAK_EN != 0) && (leak_cnt_q == LEAK_LAST);
        pot_next = (leak && (pot_sat != '0)) ? (pot_sat - 1'b1) : pot_sat;
        fire     = !grst && !fired_q && (pot_next >= thresh_q);
    end

    // Next-state logic
    always_comb begin
        pot_d         = pot_q;
        thresh_d      = thresh_q;
        tcnt_d        = tcnt_q;
        leak_cnt_d    = leak_cnt_q;
        fired_d       = fired_q;
        spike_time_d  = spike_time_q;
        spike_valid_d = 1'b0;
        no_spike_d    = 1'b0;

        // The pulse counter runs independently of gamma boundaries: grst
        // does not cut a pulse short, and a new fire reloads it seamlessly.
        if (fire) begin
            pulse_cnt_d = PULSE_LEN;
        end else if (pulse_cnt_q != '0) begin
            pulse_cnt_d = pulse_cnt_q - 1'b1;
        end else begin
            pulse_cnt_d = pulse_cnt_q;
        end

        if (grst) begin
            pot_d      = '0;
            tcnt_d     = '0;
            leak_cnt_d = '0;
            fired_d    = 1'b0;
            thresh_d   = thresh;
            no_spike_d = !fired_q;
        end else begin
            tcnt_d = (tcnt_q == TCNT_MAX) ? tcnt_q : (tcnt_q + 1'b1);
            // Once fired, the potential and leak phase are frozen until grst.
            if (!fired_q) begin
                pot_d      = pot_next;
                leak_cnt_d = (leak_cnt_q == LEAK_LAST) ? '0 : (leak_cnt_q + 1'b1);
            end
            if (fire) begin
                fired_d       = 1'b1;
                spike_time_d  = tcnt_q;
                spike_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            pot_q         <= '0;
            thresh_q      <= '0;
            tcnt_q        <= '0;
            leak_cnt_q    <= '0;
            fired_q       <= 1'b0;
            pulse_cnt_q   <= '0;
            spike_time_q  <= '0;
            spike_valid_q <= 1'b0;
            no_spike_q    <= 1'b0;
        end else begin
            pot_q         <= pot_d;
            thresh_q      <= thresh_d;
            tcnt_q        <= tcnt_d;
            leak_cnt_q    <= leak_cnt_d;
            fired_q       <= fired_d;
            pulse_cnt_q   <= pulse_cnt_d;
            spike_time_q  <= spike_time_d;
            spike_valid_q <= spike_valid_d;
            no_spike_q    <= no_spike_d;
        end
    end

    assign output_spike = (pulse_cnt_q != '0);
    assign spike_time   = spike_time_q;
    assign spike_valid  = spike_valid_q;
    assign no_spike     = no_spike_q;
    assign potential    = pot_q;

endmodule

// File: tb/tb_neuron_body_gen2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_neuron_body_gen2
//
// Table-driven bench for neuron_body_gen2. u0 is the default no-leak neuron
// and is checked against the vector table; u1 has the linear leak enabled
// and is checked in a hand-written leak / mid-pulse reset sequence.
// -----------------------------------------------------------------------------
module tb_neuron_body_gen2;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        grst = 1'b0;
    logic [15:0] acc_in = '0;
    logic [7:0]  thresh = '0;

    logic        spk0, vld0, ns0;
    logic [3:0]  tim0;
    logic [7:0]  pot0;
    logic        spk1, vld1, ns1;
    logic [3:0]  tim1;
    logic [7:0]  pot1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_body_gen2 #(
        .INP(16), .WRES(3), .POT_W(8), .TW(4), .LEAK_EN(0), .LEAK_PERIOD(4)
    ) u0 (
        .clk(clk), .rstb(rstb), .grst(grst), .acc_in(acc_in), .thresh(thresh),
        .output_spike(spk0), .spike_time(tim0), .spike_valid(vld0),
        .no_spike(ns0), .potential(pot0)
    );

    neuron_body_gen2 #(
        .INP(16), .WRES(3), .POT_W(8), .TW(4), .LEAK_EN(1), .LEAK_PERIOD(4)
    ) u1 (
        .clk(clk), .rstb(rstb), .grst(grst), .acc_in(acc_in), .thresh(thresh),
        .output_spike(spk1), .spike_time(tim1), .spike_valid(vld1),
        .no_spike(ns1), .potential(pot1)
    );

    typedef struct {
        logic        rstb;
        logic        grst;
        logic [15:0] acc;
        logic [7:0]  thr;
        int          pot;
        int          spk;
        int          vld;
        int          tim;
        int          ns;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic g, input logic [15:0] a,
                       input logic [7:0] t, input int p, input int s,
                       input int v, input int tm, input int n);
        vec_t x;
        x.rstb = r; x.grst = g; x.acc = a; x.thr = t;
        x.pot = p; x.spk = s; x.vld = v; x.tim = tm; x.ns = n;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Apply inputs, advance one clock, sample 1 ns after the edge.
    task automatic step(input logic r, input logic g, input logic [15:0] a,
                        input logic [7:0] t);
        rstb   = r;
        grst   = g;
        acc_in = a;
        thresh = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- Vector table ----------------
        // Reset with grst pulsing and all synapses active
        add(0, 1, 16'hFFFF, 8'd0, 0, 0, 0, 0, 0);
        add(0, 0, 16'hFFFF, 8'd0, 0, 0, 0, 0, 0);
        add(0, 1, 16'hFFFF, 8'd0, 0, 0, 0, 0, 0);
        // First grst after reset: previous gamma silent
        add(1, 1, 16'h0000, 8'd13, 0, 0, 0, 0, 1);
        // Basic fire: +4 per cycle, fires on 16 at tcnt=3
        for (int k = 1; k <= 3; k++) add(1, 0, 16'h000F, 8'd13, 4 * k, 0, 0, 0, 0);
        add(1, 0, 16'h000F, 8'd13, 16, 1, 1, 3, 0);
        // One spike per gamma: pulse lasts 8 cycles, potential frozen
        for (int i = 0; i < 20; i++) add(1, 0, 16'hFFFF, 8'd13, 16, (i < 7) ? 1 : 0, 0, 3, 0);
        add(1, 1, 16'h0000, 8'd13, 0, 0, 0, 3, 0);
        // Silent gamma
        for (int i = 0; i < 10; i++) add(1, 0, 16'h0000, 8'd13, 0, 0, 0, 3, 0);
        add(1, 1, 16'h0000, 8'd13, 0, 0, 0, 3, 1);
        add(1, 0, 16'h0000, 8'd13, 0, 0, 0, 3, 0);
        // Saturation: acc_in ignored on grst, then +16 per cycle
        add(1, 1, 16'hFFFF, 8'd255, 0, 0, 0, 3, 1);
        for (int k = 1; k <= 15; k++) add(1, 0, 16'hFFFF, 8'd255, 16 * k, 0, 0, 3, 0);
        add(1, 0, 16'hFFFF, 8'd255, 255, 1, 1, 15, 0);
        // Retrigger: grst mid-pulse with thresh=0, refire reloads the pulse
        add(1, 1, 16'h0000, 8'd0, 0, 1, 0, 15, 0);
        add(1, 0, 16'h0000, 8'd0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 16'h0000, 8'd0, 0, 1, 0, 0, 0);
        add(1, 0, 16'h0000, 8'd0, 0, 0, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rstb, vecs[i].grst, vecs[i].acc, vecs[i].thr);
            $display("vec %0d rstb=%0d grst=%0d acc=%h thr=%0d -> pot=%0d spk=%0d vld=%0d time=%0d ns=%0d",
                     i, vecs[i].rstb, vecs[i].grst, vecs[i].acc, vecs[i].thr,
                     pot0, spk0, vld0, tim0, ns0);
            chk("potential",    i, int'(pot0), vecs[i].pot);
            chk("output_spike", i, int'(spk0), vecs[i].spk);
            chk("spike_valid",  i, int'(vld0), vecs[i].vld);
            chk("spike_time",   i, int'(tim0), vecs[i].tim);
            chk("no_spike",     i, int'(ns0),  vecs[i].ns);
            if (i < 3) begin
                chk("leak_reset_spk", i, int'(spk1), 0);
                chk("leak_reset_pot", i, int'(pot1), 0);
            end
        end

        // ---------------- Leak sequence on u1 ----------------
        begin
            int exp_pot[6] = '{1, 2, 3, 3, 4, 5};
            step(1, 1, 16'h0000, 8'd5);
            $display("leak grst -> pot=%0d", pot1);
            chk("leak_grst_pot", 0, int'(pot1), 0);
            for (int c = 0; c < 6; c++) begin
                step(1, 0, 16'h0001, 8'd5);
                $display("leak cyc %0d -> pot=%0d vld=%0d time=%0d spk=%0d",
                         c, pot1, vld1, tim1, spk1);
                chk("leak_pot", c, int'(pot1), exp_pot[c]);
                chk("leak_vld", c, int'(vld1), (c == 5) ? 1 : 0);
            end
            chk("leak_time", 6, int'(tim1), 5);
            chk("leak_spk",  6, int'(spk1), 1);
            // Second pulse cycle
            step(1, 0, 16'h0001, 8'd5);
            $display("leak pulse2 -> spk=%0d", spk1);
            chk("leak_pulse2", 7, int'(spk1), 1);
            // Reset in the third pulse cycle aborts the pulse
            step(0, 0, 16'h0001, 8'd5);
            $display("leak rst -> spk=%0d pot=%0d time=%0d u0spk=%0d", spk1, pot1, tim1, spk0);
            chk("rst_abort_spk",  8, int'(spk1), 0);
            chk("rst_abort_pot",  8, int'(pot1), 0);
            chk("rst_abort_time", 8, int'(tim1), 0);
            chk("rst_abort_u0",   8, int'(spk0), 0);
            step(1, 0, 16'h0000, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_body_gen2.md
Name: neuron_body_gen2

Overview:
- Next-generation SRM0 neuron soma: accumulates per-synapse unary response bits into a membrane potential, with a runtime threshold, optional linear leak, one spike per gamma cycle, and spike-time reporting.
- Converts the firing event into a 2^WRES-cycle output pulse for the next layer.
- Sits between the synapse array and the next column stage, in the same gamma-clocked temporal pipeline.

Parameters:
- INP, 16, number of synapse inputs.
- WRES, 3, weight resolution; output pulse width = 2^WRES cycles.
- POT_W, 8, membrane potential width; saturating unsigned.
- TW, 4, spike-time counter width; saturating.
- LEAK_EN, 0, 0 = ramp-no-leak; 1 = linear leak enabled.
- LEAK_PERIOD, 4, cycles per leak decrement of 1 (>=1, used only if LEAK_EN=1).

Ports:
- clk  in  1  unit clock.
- rstb  in  1  synchronous active-low reset.
- grst  in  1  1-cycle gamma-cycle start pulse.
- acc_in  in  INP  unary synapse responses; each high bit adds 1 to potential that cycle.
- thresh  in  POT_W  firing threshold; sampled into thresh_q on grst.
- output_spike  out  1  2^WRES-cycle-wide output pulse.
- spike_time  out  TW  tcnt value at firing; held until next firing or reset.
- spike_valid  out  1  1-cycle strobe: spike_time updated.
- no_spike  out  1  1-cycle strobe at grst if the previous gamma cycle produced no spike.
- potential  out  POT_W  current membrane potential (debug/observe).

Behaviour:
- Reset (rstb=0 at clk edge): pot, thresh_q, tcnt, leak_cnt, fired, pulse counter, spike_time cleared to 0. All outputs 0 the cycle after. rstb dominates grst and aborts any in-flight pulse.
- grst=1 (rstb=1):
  - pot<=0, tcnt<=0, leak_cnt<=0, fired<=0, thresh_q<=thresh.
  - acc_in is ignored that cycle; no fire evaluation.
  - no_spike<=~fired (previous gamma state).
  - An in-progress output pulse is NOT truncated.
  - After rstb deassertion, before the first grst: thresh_q=0 and fired=0, so the neuron fires on the first non-grst cycle; no_spike is asserted on the first grst.
- Normal cycle (rstb=1, grst=0, fired=0):
  - sum = popcount(acc_in), width clog2(INP+1).
  - leak = 1 if LEAK_EN and leak_cnt==LEAK_PERIOD-1, else 0.
  - pot_next = min(pot+sum, 2^POT_W-1), then minus leak, floored at 0. Compute at POT_W+1 bits.
  - pot<=pot_next. leak_cnt wraps modulo LEAK_PERIOD. tcnt<=min(tcnt+1, 2^TW-1).
- Fire: if fired=0 and pot_next>=thresh_q in a normal cycle:
  - fired<=1; spike_time<=tcnt (pre-increment value).
  - spike_valid=1 next cycle.
  - output_spike high starting next cycle for exactly 2^WRES cycles.
  - Latency from accumulation cycle to output edge is 1 cycle.
- fired=1: pot, leak_cnt frozen; tcnt keeps counting; acc_in ignored. No further fire until the next grst.
- Retrigger: a fire while output_spike is still high reloads the pulse counter, so output stays high 2^WRES cycles from the new fire. There is no gap.
- thresh_q=0: fires in the first normal cycle after grst, spike_time=0.
- Pulse counter width WRES+1; output_spike = (count != 0).

Test Plan (INP=16, WRES=3, POT_W=8, TW=4, LEAK_EN=0 unless stated):
1. Reset: rstb=0 for 3 cycles with acc_in=FFFF and grst pulsing -> all outputs 0, potential=0.
2. Basic fire: grst with thresh=13, then acc_in=000F for 4 cycles.
   - potential reads 4, 8, 12, then fires on 16 at tcnt=3.
   - Next cycle: spike_valid=1, spike_time=3; output_spike high exactly 8 cycles.
3. Single spike per gamma: after scenario 2, hold acc_in=FFFF for 20 cycles -> no second spike_valid; potential stays 16; next grst gives no_spike=0.
4. Silent gamma: grst, thresh=13, acc_in=0 for 10 cycles, grst -> no_spike=1 for one cycle at the second grst; spike_valid never asserted.
5. Saturation and retrigger:
   - thresh=255, acc_in=FFFF -> potential saturates at 255 on the 16th cycle; spike_time=15.
   - Then grst, thresh=0 while the pulse is still high -> pulse reloaded; 8 more high cycles counted from the new fire, with no low gap.
6. Leak and mid-pulse reset:
   - LEAK_EN=1, LEAK_PERIOD=4, thresh=5, acc_in=0001 -> net +3 per 4 cycles; potential reads 1, 2, 3, 3, 4, then fires at tcnt=5 (pot_next=5).
   - Assert rstb=0 in the 3rd pulse cycle -> output_spike=0 the next cycle.
